uart_rx_capture: RTL

- Synthesizable 8N1 UART receiver with a small first-word-fall-through (FWFT) receive FIFO.
- Consumes the serial stream the SoC drives out on mprj_io[6] (uart_tx).
- Hands decoded bytes to a ready/valid consumer (scoreboard, LA capture or user-project logic).
- Flags framing and overrun errors so the firmware checkpoint flow (0xAB10/0xAB11 matmul, 0xAB20/0xAB21 qsort) can be cross-checked against printed UART output.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_fifo.sv | 72 +++++++
 rtl/uart_rx_capture.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_state_t;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_CLKS_PER_BIT_DEFAULT = 4167;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small first-word-fall-through FIFO; head entry is presented whenever not empty.
module uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [DATA_W-1:0]          i_data,
    input  logic                       i_pop,
    output logic [DATA_W-1:0]          o_data,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_overrun
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overrun;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !w_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= i_push && w_full && !w_do_pop;
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data    = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_empty   = w_empty;
    assign o_full    = w_full;
    assign o_count   = r_count;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/uart_rx_capture.sv
// 8N1 UART receiver feeding a FWFT FIFO; define UART_RX_PARITY_EN for 8E1 with parity check.
module uart_rx_capture
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clock,
    input  logic                          resetb,
    input  logic                          ser_rx,
    output logic [UART_DATA_BITS-1:0]     rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          busy
);

    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        LAST_BIT  = 3'(UART_DATA_BITS - 1);

    logic [1:0]                r_sync;
    uart_state_t               r_state;
    logic [CNT_W-1:0]          r_baud_cnt;
    logic [2:0]                r_bit_cnt;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      r_frame_err;

    uart_state_t               w_state_next;
    logic [CNT_W-1:0]          w_cnt_next;
    logic [2:0]                w_bit_next;
    logic [UART_DATA_BITS-1:0] w_shift_next;
    logic                      w_frame_err_next;
    logic                      w_push;
    logic                      w_rxs;
    logic                      w_half_tick;
    logic                      w_full_tick;
    logic                      w_empty;
    logic                      w_fifo_full;

`ifdef UART_RX_PARITY_EN
    logic r_par_err;
    logic w_par_err_next;
`endif

    assign w_rxs       = r_sync[1];
    assign w_half_tick = (r_baud_cnt == HALF_LAST);
    assign w_full_tick = (r_baud_cnt == FULL_LAST);

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_baud_cnt + CNT_W'(1);
        w_bit_next       = r_bit_cnt;
        w_shift_next     = r_shift;
        w_frame_err_next = 1'b0;
        w_push           = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_err_next   = r_par_err;
`endif
        case (r_state)
            IDLE: begin
                w_cnt_next = '0;
                if (!w_rxs) begin
                    w_state_next = START;
                end
            end
            START: begin
                if (w_half_tick) begin
                    w_cnt_next   = '0;
                    w_bit_next   = '0;
                    w_state_next = w_rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_full_tick) begin
                    w_cnt_next   = '0;
                    w_shift_next = {w_rxs, r_shift[UART_DATA_BITS-1:1]};
                    w_bit_next   = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (w_full_tick) begin
                    w_cnt_next     = '0;
                    w_par_err_next = w_rxs ^ (^r_shift);
                    w_state_next   = STOP;
                end
            end
`endif
            STOP: begin
                if (w_full_tick) begin
                    w_cnt_next = '0;
                    if (w_rxs) begin
                        w_state_next = IDLE;
`ifdef UART_RX_PARITY_EN
                        w_push           = !r_par_err;
                        w_frame_err_next = r_par_err;
`else
                        w_push           = 1'b1;
`endif
                    end else begin
                        // Stop bit low: drop the byte and wait out a held-low line.
                        w_frame_err_next = 1'b1;
                        w_state_next     = BREAK;
                    end
                end
            end
            BREAK: begin
                w_cnt_next = '0;
                if (w_rxs) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_cnt_next   = '0;
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_sync      <= 2'b11;
            r_state     <= IDLE;
            r_baud_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_sync      <= {r_sync[0], ser_rx};
            r_state     <= w_state_next;
            r_baud_cnt  <= w_cnt_next;
            r_bit_cnt   <= w_bit_next;
            r_shift     <= w_shift_next;
            r_frame_err <= w_frame_err_next;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_par_err <= 1'b0;
        end else begin
            r_par_err <= w_par_err_next;
        end
    end
`endif

    uart_rx_fifo #(
        .DATA_W (UART_DATA_BITS),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clock),
        .rst_n     (resetb),
        .i_push    (w_push),
        .i_data    (r_shift),
        .i_pop     (rx_ready),
        .o_data    (rx_data),
        .o_empty   (w_empty),
        .o_full    (w_fifo_full),
        .o_count   (fifo_count),
        .o_overrun (overrun)
    );

    // Full status is reflected in fifo_count; the flag itself is not needed here.
    logic w_unused_full;
    assign w_unused_full = w_fifo_full;

    assign rx_valid  = !w_empty;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != IDLE);

endmodule
